// File: rtl/rom_dl_pkg.sv
// Shared types and widths for the ROM download controller.
package rom_dl_pkg;

    localparam int ADDR_W   = 16;
    localparam int LEN_W    = 17;
    localparam int IOCTL_AW = 25;
    localparam int DATA_W   = 8;

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } dl_state_t;

endpackage

// File: rtl/rom_download_ctrl_rst_hold_timer.sv
// Core-reset stretch timer: start clears the count, done flags the last
// clock of a HOLD_CYC-long window while enabled.
module rst_hold_timer #(
    parameter int HOLD_CYC = 1024
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic start,
    input  logic enable,
    output logic done
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [CW-1:0] cnt;

    assign done = enable && (cnt == CW'(HOLD_CYC - 1));

    // Count clocks spent in the hold window; a start request wins and restarts it.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (enable && !done) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rom_download_ctrl.sv
// ROM download controller: receives the HPS ioctl byte stream, forwards
// in-range bytes to the core ROM port one clock later, validates the image
// length (and, with ROM_CHECKSUM_EN defined, the additive checksum against
// EXP_SUM), then holds the core in reset for HOLD_CYC clocks before release.
module rom_download_ctrl
    import rom_dl_pkg::*;
#(
    parameter logic [LEN_W-1:0] IMAGE_LEN = 17'h05020,
    parameter int               HOLD_CYC  = 1024,
    parameter logic [7:0]       EXP_SUM   = 8'h00
) (
    input  logic                clk_sys,
    input  logic                RESET_N,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [DATA_W-1:0]   ioctl_dout,
    input  logic                user_reset,
    output logic                core_reset,
    output logic [ADDR_W-1:0]   dn_addr,
    output logic [DATA_W-1:0]   dn_data,
    output logic                dn_wr,
    output logic                load_done,
    output logic                load_error,
    output logic [7:0]          checksum
);

    dl_state_t        state;
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] cnt_next;
    logic             overflow;
    logic             ovf_next;
    logic             wr_hit;
    logic             sum_ok;
    logic             image_ok;
    logic             load_start;
    logic             finish_ok;
    logic             hold_start;
    logic             hold_done;

    assign wr_hit     = ioctl_wr && (ioctl_addr < IOCTL_AW'(IMAGE_LEN));
    assign load_start = ioctl_download && (state == BOOT || state == RUN || state == ERR);

    // Length and overflow state as they will be after this clock, so a write
    // coinciding with the download falling edge is part of the verdict.
    always_comb begin
        cnt_next = byte_cnt;
        if (wr_hit && (byte_cnt != IMAGE_LEN)) begin
            cnt_next = byte_cnt + LEN_W'(1);
        end
        ovf_next = overflow | (ioctl_wr & ~wr_hit);
    end

`ifdef ROM_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_next;

    assign sum_next = sum_q + (wr_hit ? ioctl_dout : 8'h00);
    assign sum_ok   = (sum_next == EXP_SUM);
    assign checksum = sum_q;

    // Running additive sum of accepted bytes, cleared when a new download starts.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_q <= 8'h00;
        end else if (load_start) begin
            sum_q <= 8'h00;
        end else if (state == LOAD && wr_hit) begin
            sum_q <= sum_next;
        end
    end
`else
    // EXP_SUM stays on the interface so both builds share one parameter list.
    logic unused_exp_sum;
    assign unused_exp_sum = ^EXP_SUM;
    assign sum_ok         = 1'b1;
    assign checksum       = 8'h00;
`endif

    assign image_ok   = (cnt_next == IMAGE_LEN) && !ovf_next && sum_ok;
    assign finish_ok  = (state == LOAD) && !ioctl_download && image_ok;
    assign hold_start = finish_ok
                      || (state == HOLD && user_reset)
                      || (state == RUN && user_reset && !ioctl_download);

    rst_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk_sys (clk_sys),
        .rst_n   (RESET_N),
        .start   (hold_start),
        .enable  (state == HOLD),
        .done    (hold_done)
    );

    // Main controller: download sequencing, ROM write pipeline and core reset.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= BOOT;
            core_reset <= 1'b1;
            dn_wr      <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            byte_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            dn_wr <= 1'b0;
            if (state == LOAD) begin
                byte_cnt <= cnt_next;
                overflow <= ovf_next;
                if (wr_hit) begin
                    dn_wr   <= 1'b1;
                    dn_addr <= ioctl_addr[ADDR_W-1:0];
                    dn_data <= ioctl_dout;
                end
            end

            case (state)
                BOOT: begin
                    core_reset <= 1'b1;
                    if (ioctl_download) begin
                        state      <= LOAD;
                        byte_cnt   <= '0;
                        overflow   <= 1'b0;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                LOAD: begin
                    core_reset <= 1'b1;
                    if (!ioctl_download) begin
                        if (image_ok) begin
                            state     <= HOLD;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ERR;
                            load_error <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    core_reset <= 1'b1;
                    if (!user_reset && hold_done) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end
                end
                RUN: begin
                    core_reset <= 1'b0;
                    if (ioctl_download) begin
                        state      <= LOAD;
                        core_reset <= 1'b1;
                        byte_cnt   <= '0;
                        overflow   <= 1'b0;
                        load_done  <= 1'b0;
                    end else if (user_reset) begin
                        state      <= HOLD;
                        core_reset <= 1'b1;
                    end
                end
                ERR: begin
                    core_reset <= 1'b1;
                    if (ioctl_download) begin
                        state      <= LOAD;
                        byte_cnt   <= '0;
                        overflow   <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                default: begin
                    state      <= BOOT;
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl in its default build.
module tb_rom_download_ctrl;

    logic        clk_sys;
    logic        RESET_N;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset;
    logic        core_reset;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        load_done;
    logic        load_error;
    logic [7:0]  checksum;

    int compared   = 0;
    int mismatched = 0;
    int dn_pulses  = 0;
    int pipe_errs  = 0;
    int edges      = 0;
    int stray      = 0;

    rom_download_ctrl #(
        .IMAGE_LEN (17'h05020),
        .HOLD_CYC  (1024),
        .EXP_SUM   (8'h00)
    ) dut (
        .clk_sys        (clk_sys),
        .RESET_N        (RESET_N),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .user_reset     (user_reset),
        .core_reset     (core_reset),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .load_done      (load_done),
        .load_error     (load_error),
        .checksum       (checksum)
    );

    // Free-running system clock, period 10.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] pat(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one clock worth of inputs at the falling edge, return just after the rising edge.
    task automatic applyStimulus(input bit dl, input bit wr, input logic [24:0] a,
                                 input logic [7:0] d, input bit ur);
        @(negedge clk_sys);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = a;
        ioctl_dout     = d;
        user_reset     = ur;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic writeByte(input logic [24:0] a, input bit expect_acc, input bit drop_dl);
        applyStimulus(!drop_dl, 1'b1, a, pat(a), 1'b0);
        if (dn_wr) dn_pulses++;
        if (dn_wr !== expect_acc) pipe_errs++;
        else if (expect_acc && (dn_addr !== a[15:0] || dn_data !== pat(a))) pipe_errs++;
    endtask

    task automatic loadRange(input int first, input int n, input bit drop_last);
        for (int i = 0; i < n; i++) begin
            writeByte(25'(first + i), 1'b1, drop_last && (i == n - 1));
        end
    endtask

    // Count rising edges from hold entry until core_reset drops; optional user_reset pulse.
    task automatic measureHold(input int pulse_at, output int n);
        n = -1;
        for (int k = 1; k <= 4000; k++) begin
            applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, k == pulse_at);
            if (dn_wr) pipe_errs++;
            if (!core_reset) begin
                n = k;
                break;
            end
        end
        user_reset = 1'b0;
    endtask

    initial begin
        RESET_N        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        user_reset     = 1'b0;

        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("rst_dn_wr", 32'(dn_wr), 32'd0);
        checkOutput("rst_dn_addr", 32'(dn_addr), 32'd0);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_load_error", 32'(load_error), 32'd0);
        checkOutput("rst_checksum", 32'(checksum), 32'd0);
        @(negedge clk_sys);
        RESET_N = 1'b1;

        // Writes without a download in progress are ignored in BOOT.
        applyStimulus(1'b0, 1'b1, 25'd5, 8'h11, 1'b0);
        applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, 1'b0);
        checkOutput("boot_no_wr", 32'(dn_wr), 32'd0);
        checkOutput("boot_core_reset", 32'(core_reset), 32'd1);

        // Short image: 0x5000 bytes, then drop download.
        applyStimulus(1'b1, 1'b0, 25'd0, 8'd0, 1'b0);
        dn_pulses = 0;
        pipe_errs = 0;
        loadRange(0, 32'h5000, 1'b0);
        applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 1'b0);
        checkOutput("short_load_error", 32'(load_error), 32'd1);
        checkOutput("short_load_done", 32'(load_done), 32'd0);
        checkOutput("short_dn_pulses", 32'(dn_pulses), 32'h5000);
        checkOutput("short_pipe_errs", 32'(pipe_errs), 32'd0);
        repeat (20) applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 1'b0);
        checkOutput("err_core_reset", 32'(core_reset), 32'd1);
        checkOutput("err_sticky", 32'(load_error), 32'd1);

        // Full image; last byte arrives in the same clock as the download drop.
        applyStimulus(1'b1, 1'b0, 25'd0, 8'd0, 1'b0);
        checkOutput("err_exit_clear", 32'(load_error), 32'd0);
        dn_pulses = 0;
        pipe_errs = 0;
        loadRange(0, 32'h5020, 1'b1);
        checkOutput("full_load_done", 32'(load_done), 32'd1);
        checkOutput("full_load_error", 32'(load_error), 32'd0);
        checkOutput("full_core_reset", 32'(core_reset), 32'd1);
        measureHold(0, edges);
        checkOutput("full_hold_len", 32'(edges), 32'd1024);
        checkOutput("full_dn_pulses", 32'(dn_pulses), 32'h5020);
        checkOutput("full_pipe_errs", 32'(pipe_errs), 32'd0);
        checkOutput("run_core_reset", 32'(core_reset), 32'd0);
        checkOutput("run_checksum", 32'(checksum), 32'd0);

        // User reset from RUN: plain hold.
        pipe_errs = 0;
        applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 1'b1);
        checkOutput("ureset_enter", 32'(core_reset), 32'd1);
        checkOutput("ureset_load_done", 32'(load_done), 32'd1);
        measureHold(0, edges);
        checkOutput("ureset_hold_len", 32'(edges), 32'd1024);

        // User reset again, re-pressed 500 clocks into the hold.
        applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 1'b1);
        measureHold(500, edges);
        checkOutput("restart_hold_len", 32'(edges), 32'd1524);
        checkOutput("hold_no_dn_wr", 32'(pipe_errs), 32'd0);

        // New download from RUN with out-of-range writes.
        applyStimulus(1'b1, 1'b0, 25'd0, 8'd0, 1'b0);
        checkOutput("reload_done_clr", 32'(load_done), 32'd0);
        checkOutput("reload_core_reset", 32'(core_reset), 32'd1);
        dn_pulses = 0;
        pipe_errs = 0;
        writeByte(25'h0, 1'b1, 1'b0);
        writeByte(25'h1, 1'b1, 1'b0);
        writeByte(25'h2, 1'b1, 1'b0);
        writeByte(25'h6000, 1'b0, 1'b0);
        writeByte(25'h5020, 1'b0, 1'b0);
        writeByte(25'h501F, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 1'b0);
        checkOutput("ovf_dn_pulses", 32'(dn_pulses), 32'd4);
        checkOutput("ovf_pipe_errs", 32'(pipe_errs), 32'd0);
        checkOutput("ovf_load_error", 32'(load_error), 32'd1);

        // Reset asserted mid-load at byte 0x100.
        applyStimulus(1'b1, 1'b0, 25'd0, 8'd0, 1'b0);
        checkOutput("abort_err_clr", 32'(load_error), 32'd0);
        pipe_errs = 0;
        loadRange(0, 32'h100, 1'b0);
        checkOutput("abort_pre_dn_addr", 32'(dn_addr), 32'hFF);
        @(negedge clk_sys);
        ioctl_addr = 25'h100;
        ioctl_dout = pat(25'h100);
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("abort_core_reset", 32'(core_reset), 32'd1);
        checkOutput("abort_dn_wr", 32'(dn_wr), 32'd0);
        checkOutput("abort_dn_addr", 32'(dn_addr), 32'd0);
        checkOutput("abort_dn_data", 32'(dn_data), 32'd0);
        checkOutput("abort_load_error", 32'(load_error), 32'd0);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        RESET_N        = 1'b1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 25'd0, 8'd0, 1'b0);
            if (dn_wr) stray++;
        end
        checkOutput("post_abort_no_dn_wr", 32'(stray), 32'd0);
        checkOutput("post_abort_core_reset", 32'(core_reset), 32'd1);
        checkOutput("post_abort_load_error", 32'(load_error), 32'd0);
        checkOutput("post_abort_load_done", 32'(load_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
